// File: rtl/skinny_pkg.sv
// Shared types and helpers for the masked SKINNY-128-128 share loader.
package skinny_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY   = 32'h80200003;
  localparam int          BLOCK_BYTES = 16;
  localparam int          TOTAL_BYTES = 32;

  // Galois right-shift step: feedback bit is the bit shifted out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    logic [31:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ LFSR_POLY;
    return n;
  endfunction

endpackage

// File: rtl/skinny_mask_lfsr.sv
// 32-bit Galois LFSR mask generator; low byte of the state is the current mask.
module skinny_mask_lfsr
  import skinny_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [7:0]  mask
);

  logic [31:0] lfsr_reg;

  // An all-zero state would lock the generator, so a zero seed becomes 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_reg <= '0;
    end else if (clear) begin
      lfsr_reg <= '0;
    end else if (load) begin
      lfsr_reg <= (seed == 32'd0) ? 32'h00000001 : seed;
    end else if (step) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign mask = lfsr_reg[7:0];

endmodule

// File: rtl/skinny_share_loader.sv
// Front end for the masked SKINNY core: byte-stream loading, Boolean share
// splitting, core reset sequencing, run timeout and zeroization.
module skinny_share_loader
  import skinny_pkg::*;
#(
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         start,
  input  logic [31:0]  mask_seed,
  input  logic [79:0]  prng_seed,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] plaintext_s0,
  output logic [127:0] plaintext_s1,
  output logic [127:0] key_s0,
  output logic [127:0] key_s1,
  output logic [79:0]  seed,
  output logic         core_rst,
  input  logic         core_done,
  output logic         busy,
  output logic         complete,
  output logic         timeout
);

  state_t         state_reg;
  logic [4:0]     cnt_reg;
  logic [15:0]    run_cnt_reg;
  logic [127:0]   pt_s0_reg, pt_s1_reg, key_s0_reg, key_s1_reg;
  logic [79:0]    seed_reg;
  logic           timeout_reg;

  logic           start_ok;
  logic           accept;
  logic [7:0]     mask;
  logic [7:0]     masked_byte;
  logic [6:0]     slot_lsb;

  assign start_ok    = start && !clear && (state_reg == ST_IDLE || state_reg == ST_DONE);
  assign accept      = in_valid && !clear && (state_reg == ST_LOAD);
  assign masked_byte = in_data ^ mask;
  // Byte k lands in bits [127-8k -: 8]; for a 4-bit k that LSB is {~k, 3'b0}.
  assign slot_lsb    = {~cnt_reg[3:0], 3'b000};

  skinny_mask_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .load  (start_ok),
    .seed  (mask_seed),
    .step  (accept),
    .mask  (mask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      run_cnt_reg <= '0;
      pt_s0_reg   <= '0;
      pt_s1_reg   <= '0;
      key_s0_reg  <= '0;
      key_s1_reg  <= '0;
      seed_reg    <= '0;
      timeout_reg <= 1'b0;
    end else if (clear) begin
      // Zeroize everything secret; the timeout flag survives for inspection.
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      run_cnt_reg <= '0;
      pt_s0_reg   <= '0;
      pt_s1_reg   <= '0;
      key_s0_reg  <= '0;
      key_s1_reg  <= '0;
      seed_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg   <= ST_LOAD;
            seed_reg    <= prng_seed;
            timeout_reg <= 1'b0;
            cnt_reg     <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (cnt_reg[4]) begin
              key_s0_reg[slot_lsb +: 8] <= mask;
              key_s1_reg[slot_lsb +: 8] <= masked_byte;
            end else begin
              pt_s0_reg[slot_lsb +: 8]  <= mask;
              pt_s1_reg[slot_lsb +: 8]  <= masked_byte;
            end
            cnt_reg <= cnt_reg + 5'd1;
            if (cnt_reg == 5'(TOTAL_BYTES - 1)) state_reg <= ST_START;
          end
        end
        ST_START: begin
          run_cnt_reg <= '0;
          state_reg   <= ST_RUN;
        end
        ST_RUN: begin
          if (core_done) begin
            state_reg <= ST_DONE;
          end else if (run_cnt_reg == 16'(RUN_TIMEOUT - 1)) begin
            timeout_reg <= 1'b1;
            pt_s0_reg   <= '0;
            pt_s1_reg   <= '0;
            key_s0_reg  <= '0;
            key_s1_reg  <= '0;
            seed_reg    <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            run_cnt_reg <= run_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state_reg == ST_LOAD);
  assign busy         = (state_reg == ST_LOAD) || (state_reg == ST_START) || (state_reg == ST_RUN);
  assign complete     = (state_reg == ST_DONE);
  assign core_rst     = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) || (state_reg == ST_START);
  assign timeout      = timeout_reg;
  assign plaintext_s0 = pt_s0_reg;
  assign plaintext_s1 = pt_s1_reg;
  assign key_s0       = key_s0_reg;
  assign key_s1       = key_s1_reg;
  assign seed         = seed_reg;

endmodule

// File: doc/skinny_share_loader.md
# skinny_share_loader

Upstream front end for the masked SKINNY-128-128 core:
- Accepts an unshared plaintext and key as a 32-byte stream.
- Splits every byte into two Boolean shares using an internal LFSR mask generator.
- Holds the core in reset while the shares settle, then releases it and waits for its `done`.
- Owns the `clear` zeroization path for share registers and exposes a run timeout.

## Interface
- `RUN_TIMEOUT`, default 4096: maximum cycles in RUN before abort; valid range 2..65535.
- `clk` input 1: system clock, single domain.
- `rst` input 1: reset. **Asynchronous, active-low.**
- `clear` input 1: synchronous zeroize/abort, active-high.
- `start` input 1: single-cycle command; latches seeds and begins loading.
- `mask_seed` input 32: LFSR seed, latched on accepted `start`.
- `prng_seed` input 80: core PRNG seed, latched on accepted `start`.
- `in_valid` input 1: input byte valid.
- `in_data` input 8: input byte.
- `in_ready` output 1: byte accepted when `in_valid & in_ready`.
- `plaintext_s0`, `plaintext_s1` output 128 each: plaintext shares.
- `key_s0`, `key_s1` output 128 each: key shares.
- `seed` output 80: registered `prng_seed`.
- `core_rst` output 1: active-high reset/hold to the core.
- `core_done` input 1: core completion.
- `busy` output 1: high in LOAD, START, RUN.
- `complete` output 1: high in DONE.
- `timeout` output 1: sticky abort flag.

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE:
  - `start` → LOAD.
  - On that same edge: latch seeds, clear `timeout`, zero the byte counter.
- DONE: `start` behaves as in IDLE.
- LOAD:
  - `in_ready=1`.
  - Byte counter `cnt` (5 bits) increments per accepted byte.
  - Byte k<16 goes to plaintext bits [127-8k -: 8]; byte 16+k goes to the same slot of key.
  - After byte 31 is accepted → START.
- LFSR step:
  - 32-bit Galois, right shift: `b=l[0]; l=l>>1; if b, l^=32'h80200003`.
  - A seed of 0 is replaced by 32'h00000001.
- Masking:
  - Mask byte `m = l[7:0]`, read before the step.
  - `_s0` byte = m; `_s1` byte = d^m.
  - LFSR steps once per accepted byte only.
- START: one cycle, `core_rst` still high, shares stable → RUN.
- RUN:
  - `core_rst=0`; cycle counter counts up from 0.
  - `core_done=1` → DONE, which holds shares and stops the counter.
  - Counter reaching `RUN_TIMEOUT-1` without `core_done` → set `timeout`, zero shares and `seed`, → IDLE.
- `core_rst` is high in IDLE, LOAD and START; low in RUN and DONE.
- `start` is ignored in LOAD, START and RUN.
- `core_done` is ignored outside RUN.
- `clear` has priority over everything. On the next edge:
  - All share registers, `seed`, LFSR and counters go to 0.
  - State → IDLE; `timeout` unchanged.
- `clear` and `start` in the same cycle: `clear` wins and `start` is dropped.

## Timing
- Reset values:
  - State IDLE.
  - All share outputs and `seed` 0.
  - `core_rst=1`; `in_ready`, `busy`, `complete`, `timeout` = 0.
- All outputs are registered or decoded from state only; no combinational input-to-output paths.
- `in_ready` rises the cycle after `start` is accepted.
- With continuous `in_valid`, the 32nd byte is accepted 32 cycles later.
- START lasts 1 cycle; `core_rst` falls 2 cycles after the last byte handshake.
- DONE is entered on the edge where `core_done` is sampled high in RUN; `complete` rises on that edge.
- Stalls (`in_valid=0`) freeze `cnt` and the LFSR indefinitely; there is no load timeout.
- Reset asserted mid-operation: immediate return to reset values; `core_rst` high asynchronously.

## Structure
- Shared package `skinny_pkg`:
  - State enum.
  - LFSR polynomial constant 32'h80200003.
  - Constants: block bytes 16, total bytes 32.
  - Function `lfsr_step`.
- One sub-module `skinny_mask_lfsr`: seed load (with zero substitution), step enable, byte output, synchronous clear.
- FSM, byte counter, share registers and run timer live in the top module.

## Test plan
- Seed masking:
  - `mask_seed=1`, plaintext bytes 00..0F, key bytes 10..1F.
  - Byte 0: `plaintext_s0[127:120]=0x01`, `plaintext_s1[127:120]=0x01`.
  - Byte 1: mask 0x03, `s1` byte = 0x02.
  - Check `s0^s1` equals plaintext/key for all 32 bytes.
- Zero seed: `mask_seed=0` → identical shares to the `mask_seed=1` run.
- Stall and handshake:
  - Random `in_valid` gaps → same shares as the back-to-back run.
  - `core_rst` falls exactly 2 cycles after the 32nd handshake.
- Completion: `core_done` pulse 10 cycles into RUN → `complete=1`, shares held, second `start` reloads.
- Timeout:
  - `RUN_TIMEOUT=8`, no `core_done` → `timeout=1` after 8 RUN cycles.
  - Shares 0, state IDLE, `core_rst=1`.
- Clear and reset:
  - `clear` asserted mid-LOAD (byte 12) → next cycle all shares 0, `in_ready=0`, IDLE.
  - `rst` low mid-RUN → `core_rst=1` without waiting for a clock edge.
